pif_bus_arb: RTL and testbench
==============================

PIF_BUS_ARB -- requirements
Module: pif_bus_arb

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- AW, 8, register address width (XI_PRWA)
- SW, 4, read sub-address width (XI_PRdSubA)
- DW, 8, write/read data width
- RD_LATENCY, 5, cycles from address drive to valid XO; legal range 1..15
- PARK_ADDR, 0, address driven on XI_PRWA when idle
REQ-002 Ports (one per line: name, direction, width, meaning; clock and reset first):
- xclk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request; held until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  register address
- suba0 / suba1  in  SW  read sub-address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid while ack is high
- XI_PWr  out  1  single-cycle write strobe to the register block
- XI_PRWA  out  AW  register address
- XI_PRdSubA  out  SW  read sub-address
- XI_PD  out  DW  write data
- XI_PRdFinished  out  1  one-cycle pulse at read completion
- XO  in  8  register-block readback data; the low DW bits are used

Function
REQ-003 All outputs are registered. FSM states: IDLE, WR, RD, DONE.
REQ-004 IDLE: if exactly one req is high, grant that requester. If both are high, grant the requester other than last_grant. Latch we/addr/suba/wdata of the grantee and set last_grant to the grantee.
REQ-005 IDLE -> WR when the latched we = 1, else IDLE -> RD; the transition occurs on the edge where the grant is made.
REQ-006 WR lasts 1 cycle: XI_PWr = 1, XI_PRWA = latched addr, XI_PD = latched wdata. Then -> DONE.
REQ-007 RD: XI_PRWA / XI_PRdSubA hold the latched addr/suba. A 4-bit down-counter loads RD_LATENCY-1 on entry; at count 0, capture XO[DW-1:0] into the grantee's rdata register, then -> DONE.
REQ-008 DONE lasts 1 cycle:
- ack of the grantee = 1.
- XI_PRdFinished = 1 only if the transaction was a read.
- Then -> IDLE.
- No req is sampled in DONE.
REQ-009 Latency from the cycle req is first sampled in IDLE to the ack pulse: write = 2 cycles (strobe at +1, ack at +2); read = RD_LATENCY+1 cycles.
REQ-010 Minimum spacing between grants is 3 cycles (write). With both requesters continuously requesting, grants strictly alternate.
REQ-011 Outside WR, XI_PWr = 0. In IDLE, XI_PRWA = PARK_ADDR, XI_PRdSubA = 0, XI_PD holds its last value.
REQ-012 rdata of a requester holds its last captured value until its next read completes. A write does not alter rdata.
REQ-013 If a requester drops req mid-transaction, the transaction completes unchanged and ack still pulses. Input changes after the grant have no effect.
REQ-014 ack0 and ack1 are never high in the same cycle. At most one transaction is outstanding.
REQ-015 A non-grantee's req arriving during WR/RD/DONE is held pending and is serviced from IDLE per REQ-004.

Reset
REQ-016 On sys_rst low, asynchronously:
- state = IDLE, last_grant = 1 (requester 0 wins the first tie)
- counter = 0, ack0 = ack1 = 0, rdata0 = rdata1 = 0
- XI_PWr = 0, XI_PRdFinished = 0, XI_PRWA = PARK_ADDR, XI_PRdSubA = 0, XI_PD = 0
REQ-017 Reset asserted mid-transaction aborts it with no ack and no strobe. After release, the FSM starts in IDLE.

Verification
REQ-018 Write on port 0: req0 = 1, we0 = 1, addr0 = 8'h02, wdata0 = 8'h2A -> XI_PWr = 1 for exactly one cycle with XI_PRWA = 02, XI_PD = 2A; ack0 one cycle later; ack1 never asserted.
REQ-019 Read on port 1, RD_LATENCY = 5: addr1 = 8'h01, suba1 = 4'h2, XO forced to 8'h55 -> XI_PRWA = 01 for 5 cycles; ack1 and XI_PRdFinished high together 6 cycles after request; rdata1 = 55.
REQ-020 Simultaneous req0/req1 writes held high for 12 cycles after reset -> grants alternate 0, 1, 0, 1; each ack is 3 cycles apart; no cycle has two acks.
REQ-021 Reset pulsed low during RD (count = 2) -> no ack; all outputs at reset values; a new read after release completes normally.
REQ-022 req0 read drops after 1 cycle while req1 is held -> ack0 still pulses at the normal latency; req1 is then granted from the following IDLE; rdata0 is unchanged by req1's write.

Source files
------------

// File: rtl/pif_bus_arb.sv
// pif_bus_arb
// Two-port arbiter that serialises register accesses onto a single PIF-style
// register bus (XI_* outputs, XO readback). Only one transaction is in flight
// at a time.
//
// Handshake: a requester raises reqN and holds weN/addrN/subaN/wdataN
// stable until the arbiter grants it. The arbiter samples reqN only while
// idle. Once granted, the transaction runs to completion regardless of
// further input changes. ackN is a one-cycle completion pulse. For reads,
// rdataN is valid while ackN is high and holds until the next read on that
// port completes. A requester that keeps reqN high after ackN is treated as
// making a new request.
//
// Ports:
//   xclk, sys_rst        clock, asynchronous active-low reset
//   req*/we*/addr*/suba*/wdata*   per-requester access request
//   ack*/rdata*          per-requester completion pulse and read data
//   XI_PWr               single-cycle write strobe
//   XI_PRWA/XI_PRdSubA   register address / read sub-address
//   XI_PD                write data
//   XI_PRdFinished       one-cycle pulse when a read completes
//   XO                   register-block readback data (low DW bits used)
//
// RD_LATENCY must lie in 1..15 so that RD_LATENCY-1 fits the 4-bit counter.
module pif_bus_arb #(
  parameter int AW         = 8,
  parameter int SW         = 4,
  parameter int DW         = 8,
  parameter int RD_LATENCY = 5,
  parameter int PARK_ADDR  = 0
) (
  input  logic          xclk,
  input  logic          sys_rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [SW-1:0] suba0,
  input  logic [SW-1:0] suba1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          XI_PWr,
  output logic [AW-1:0] XI_PRWA,
  output logic [SW-1:0] XI_PRdSubA,
  output logic [DW-1:0] XI_PD,
  output logic          XI_PRdFinished,
  input  logic [7:0]    XO
);

  localparam logic [AW-1:0] PARK   = AW'(PARK_ADDR);
  localparam logic [3:0]    LAT_M1 = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e     state_q;
  logic       last_grant_q;  // requester granted most recently
  logic       gnt_q;         // owner of the transaction in flight
  logic [3:0] cnt_q;         // read wait counter

  // Grantee selection and its request fields, evaluated while idle.
  logic          any_req;
  logic          gnt_d;
  logic          gnt_we;
  logic [AW-1:0] gnt_addr;
  logic [SW-1:0] gnt_suba;
  logic [DW-1:0] gnt_wdata;

  always_comb begin
    any_req   = req0 | req1;
    gnt_d     = 1'b0;
    if (req0 && req1) begin
      // Tie: whoever did not win last time goes now, so contention alternates.
      gnt_d = ~last_grant_q;
    end else begin
      gnt_d = req1;
    end
    gnt_we    = gnt_d ? we1    : we0;
    gnt_addr  = gnt_d ? addr1  : addr0;
    gnt_suba  = gnt_d ? suba1  : suba0;
    gnt_wdata = gnt_d ? wdata1 : wdata0;
  end

  // Outputs are computed alongside the next state so every one is a flop.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 1'b1;
      gnt_q          <= 1'b0;
      cnt_q          <= 4'd0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      XI_PWr         <= 1'b0;
      XI_PRWA        <= PARK;
      XI_PRdSubA     <= '0;
      XI_PD          <= '0;
      XI_PRdFinished <= 1'b0;
    end else begin
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      XI_PWr         <= 1'b0;
      XI_PRdFinished <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q        <= gnt_d;
            last_grant_q <= gnt_d;
            XI_PRWA      <= gnt_addr;
            if (gnt_we) begin
              state_q    <= S_WR;
              XI_PWr     <= 1'b1;
              XI_PD      <= gnt_wdata;
              XI_PRdSubA <= '0;
            end else begin
              state_q    <= S_RD;
              XI_PRdSubA <= gnt_suba;
              cnt_q      <= LAT_M1;
            end
          end
        end

        S_WR: begin
          state_q <= S_DONE;
          XI_PRWA <= PARK;
          ack0    <= ~gnt_q;
          ack1    <= gnt_q;
        end

        S_RD: begin
          if (cnt_q == 4'd0) begin
            state_q        <= S_DONE;
            XI_PRWA        <= PARK;
            XI_PRdSubA     <= '0;
            XI_PRdFinished <= 1'b1;
            ack0           <= ~gnt_q;
            ack1           <= gnt_q;
            if (gnt_q) begin
              rdata1 <= XO[DW-1:0];
            end else begin
              rdata0 <= XO[DW-1:0];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_DONE: begin
          // Requests are deliberately not sampled here; pending ones are
          // taken on the next idle cycle.
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pif_bus_arb.sv
// Testbench for pif_bus_arb. A transaction-level model predicts every output
// each cycle from the grant rule and the transaction age; directed scenarios
// add hand-computed literal checks.
module tb_pif_bus_arb;

  localparam int AW     = 8;
  localparam int SW     = 4;
  localparam int DW     = 8;
  localparam int RD_LAT = 5;
  localparam int PARK   = 0;

  // ---------------- clock / reset / DUT ----------------
  logic          xclk;
  logic          sys_rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [SW-1:0] suba0, suba1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          XI_PWr;
  logic [AW-1:0] XI_PRWA;
  logic [SW-1:0] XI_PRdSubA;
  logic [DW-1:0] XI_PD;
  logic          XI_PRdFinished;
  logic [7:0]    XO;

  initial begin
    xclk = 1'b0;
    forever #5 xclk = ~xclk;
  end

  pif_bus_arb #(
    .AW(AW), .SW(SW), .DW(DW), .RD_LATENCY(RD_LAT), .PARK_ADDR(PARK)
  ) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .suba0(suba0), .suba1(suba1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA), .XI_PRdSubA(XI_PRdSubA),
    .XI_PD(XI_PD), .XI_PRdFinished(XI_PRdFinished), .XO(XO)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic xo_auto = 1'b0;
  logic [0:0] ack_port_q[$];
  int         ack_cyc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transaction is described by its age in clock edges since the grant.
  // Its completion pulse lands at age ack_age (1 for writes, RD_LAT for
  // reads) and the bus is idle again one edge later.
  logic       m_active, m_last, m_g, m_we;
  logic [7:0] m_addr, m_wdata, m_pd;
  logic [3:0] m_suba;
  int         m_age, m_ack_age;
  logic [7:0] m_rd[2];

  always @(posedge xclk) begin
    cyc++;
    if (!sys_rst) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_pd     = 8'h00;
      m_rd[0]  = 8'h00;
      m_rd[1]  = 8'h00;
      m_age    = 0;
    end else if (m_active) begin
      m_age++;
      if (m_age == m_ack_age && !m_we) m_rd[m_g] = XO;
      if (m_age == m_ack_age + 1) m_active = 1'b0;
    end else if (req0 || req1) begin
      m_g       = (req0 && req1) ? ~m_last : req1;
      m_last    = m_g;
      m_we      = m_g ? we1 : we0;
      m_addr    = m_g ? addr1 : addr0;
      m_suba    = m_g ? suba1 : suba0;
      m_wdata   = m_g ? wdata1 : wdata0;
      m_age     = 0;
      m_ack_age = m_we ? 1 : RD_LAT;
      m_active  = 1'b1;
      if (m_we) m_pd = m_wdata;
    end

    #1;
    begin
      logic e_on, e_ack;
      e_on  = m_active && (m_age < m_ack_age);
      e_ack = m_active && (m_age == m_ack_age);
      chk("pwr",   32'(XI_PWr),         32'(m_active && m_we && m_age == 0));
      chk("prwa",  32'(XI_PRWA),        e_on ? 32'(m_addr) : 32'(PARK));
      chk("suba",  32'(XI_PRdSubA),     (e_on && !m_we) ? 32'(m_suba) : 32'd0);
      chk("pd",    32'(XI_PD),          32'(m_pd));
      chk("ack0",  32'(ack0),           32'(e_ack && m_g == 1'b0));
      chk("ack1",  32'(ack1),           32'(e_ack && m_g == 1'b1));
      chk("rdfin", 32'(XI_PRdFinished), 32'(e_ack && !m_we));
      chk("rdata0", 32'(rdata0),        32'(m_rd[0]));
      chk("rdata1", 32'(rdata1),        32'(m_rd[1]));
      chk("ack_excl", 32'(ack0 & ack1), 32'd0);
    end
    if (ack0) begin ack_port_q.push_back(1'b0); ack_cyc_q.push_back(cyc); end
    if (ack1) begin ack_port_q.push_back(1'b1); ack_cyc_q.push_back(cyc); end
  end

  always @(negedge xclk) begin
    if (xo_auto) XO = 8'(cyc * 37 + 11);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int port, input logic we, input logic [7:0] a,
                       input logic [3:0] s, input logic [7:0] d);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; suba0 = s; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; suba1 = s; wdata1 = d;
    end
  endtask

  task automatic wait_ack(input int port, input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge xclk); #2;
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack, required within %0d cycles", port, max_cyc);
    end
  endtask

  task automatic pulse_reset();
    @(negedge xclk); sys_rst = 1'b0;
    @(negedge xclk); sys_rst = 1'b1;
  endtask

  // Directed table: port, we, addr, suba, wdata
  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [3:0] suba;
    logic [7:0] wdata;
  } vec_t;
  vec_t vecs[6];

  // ---------------- stimulus ----------------
  initial begin
    int n;
    sys_rst = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; suba0 = 0; suba1 = 0; wdata0 = 0; wdata1 = 0;
    XO = 8'h00;

    // Reset values
    @(posedge xclk); #2;
    chk("rst_pwr",  32'(XI_PWr), 32'd0);
    chk("rst_prwa", 32'(XI_PRWA), 32'(PARK));
    chk("rst_pd",   32'(XI_PD), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    @(negedge xclk); sys_rst = 1'b1;

    // Single write on port 0
    @(negedge xclk); issue(0, 1'b1, 8'h02, 4'h0, 8'h2A);
    @(posedge xclk); #2;
    chk("wr_strobe", 32'(XI_PWr), 32'd1);
    chk("wr_addr",   32'(XI_PRWA), 32'h02);
    chk("wr_data",   32'(XI_PD), 32'h2A);
    chk("wr_noack",  32'(ack0), 32'd0);
    @(posedge xclk); #2;
    chk("wr_ack0",   32'(ack0), 32'd1);
    chk("wr_strobe_off", 32'(XI_PWr), 32'd0);
    chk("wr_no_ack1", 32'(ack1), 32'd0);
    @(negedge xclk); req0 = 1'b0;
    @(posedge xclk); #2;
    chk("wr_pd_hold", 32'(XI_PD), 32'h2A);

    // Read on port 1, XO = 55
    XO = 8'h55;
    @(negedge xclk); issue(1, 1'b0, 8'h01, 4'h2, 8'h00);
    for (int i = 0; i < RD_LAT; i++) begin
      @(posedge xclk); #2;
      chk("rd_addr", 32'(XI_PRWA), 32'h01);
      chk("rd_suba", 32'(XI_PRdSubA), 32'h2);
      chk("rd_noack", 32'(ack1), 32'd0);
    end
    @(posedge xclk); #2;
    chk("rd_ack1",  32'(ack1), 32'd1);
    chk("rd_fin",   32'(XI_PRdFinished), 32'd1);
    chk("rd_rdata1", 32'(rdata1), 32'h55);
    @(negedge xclk); req1 = 1'b0;
    @(posedge xclk); #2;
    chk("rd_park", 32'(XI_PRWA), 32'(PARK));

    // Contention: both write continuously for 12 cycles after reset
    pulse_reset();
    ack_port_q.delete(); ack_cyc_q.delete();
    @(negedge xclk);
    issue(0, 1'b1, 8'h10, 4'h0, 8'hA0);
    issue(1, 1'b1, 8'h11, 4'h0, 8'hB1);
    repeat (12) @(posedge xclk);
    @(negedge xclk); req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge xclk);
    #2;
    chk("alt_count", 32'(ack_port_q.size()), 32'd4);
    if (ack_port_q.size() == 4) begin
      chk("alt_order", 32'({ack_port_q[0], ack_port_q[1], ack_port_q[2], ack_port_q[3]}), 32'b0101);
      for (int i = 1; i < 4; i++)
        chk("alt_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);
    end

    // Reset in the middle of a read (counter at 2)
    XO = 8'h99;
    @(negedge xclk); issue(0, 1'b0, 8'h03, 4'h1, 8'h00);
    repeat (3) @(posedge xclk);
    @(negedge xclk); sys_rst = 1'b0; req0 = 1'b0;
    #1;
    chk("mid_rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("mid_rst_prwa", 32'(XI_PRWA), 32'(PARK));
    chk("mid_rst_suba", 32'(XI_PRdSubA), 32'd0);
    chk("mid_rst_misc", 32'({XI_PWr, XI_PRdFinished}), 32'd0);
    chk("mid_rst_pd",   32'(XI_PD), 32'd0);
    chk("mid_rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    @(negedge xclk); @(negedge xclk); sys_rst = 1'b1;
    XO = 8'h3C;
    @(negedge xclk); issue(0, 1'b0, 8'h04, 4'h0, 8'h00);
    wait_ack(0, 20, n);
    chk("post_rst_rd_lat", 32'(n), 32'(RD_LAT + 1));
    chk("post_rst_rdata0", 32'(rdata0), 32'h3C);
    @(negedge xclk); req0 = 1'b0;

    // req0 read drops after one cycle, req1 write pending
    XO = 8'h77;
    @(negedge xclk); issue(0, 1'b0, 8'h05, 4'h3, 8'h00);
    @(negedge xclk);
    req0 = 1'b0; we0 = 1'b1; addr0 = 8'hFF;
    issue(1, 1'b1, 8'h06, 4'h0, 8'hC3);
    #1 chk("drop_addr_kept", 32'(XI_PRWA), 32'h05);
    wait_ack(0, 20, n);
    chk("drop_ack0_lat", 32'(n), 32'(RD_LAT));
    chk("drop_rdata0", 32'(rdata0), 32'h77);
    XO = 8'h11;
    wait_ack(1, 20, n);
    chk("pending_ack1_lat", 32'(n), 32'd3);
    chk("pending_rdata0", 32'(rdata0), 32'h77);
    @(negedge xclk); req1 = 1'b0;

    // Directed mix with XO changing every cycle
    vecs[0] = '{1'b0, 1'b0, 8'h21, 4'h5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h22, 4'h0, 8'h5A};
    vecs[2] = '{1'b1, 1'b0, 8'h23, 4'hF, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'hFE, 4'h0, 8'hFF};
    vecs[4] = '{1'b0, 1'b0, 8'h80, 4'h8, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h7F, 4'h7, 8'h00};
    xo_auto = 1'b1;
    for (int v = 0; v < 6; v++) begin
      @(negedge xclk);
      issue(int'(vecs[v].port), vecs[v].we, vecs[v].addr, vecs[v].suba, vecs[v].wdata);
      wait_ack(int'(vecs[v].port), 20, n);
      chk("vec_latency", 32'(n), vecs[v].we ? 32'd2 : 32'(RD_LAT + 1));
      @(negedge xclk); req0 = 1'b0; req1 = 1'b0;
    end
    xo_auto = 1'b0;
    repeat (3) @(posedge xclk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000 time units");
    $fatal(1);
  end

endmodule
